// File: rtl/inst_prefetch_pkg.sv
// Shared constants for the instruction prefetch stage: address width, NOP word, FSM encoding.
package inst_prefetch_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 16;
  localparam logic [15:0] NOP = 16'h0000;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StReq   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

endpackage

// File: rtl/inst_prefetch_fifo.sv
// Synchronous FIFO of {pc, inst} entries with flush; flush overrides push and pop.
module pf_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  // A pop frees the slot, so a push into a full FIFO is accepted in the same cycle.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch: req/ack fetch from instruction memory into a FIFO, with redirect flush.
module inst_prefetch
  import inst_prefetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int unsigned       CntW  = $clog2(DEPTH) + 1;
  localparam int unsigned       EntW  = ADDR_W + 16;
  localparam logic [ADDR_W-1:0] PcOne = 1;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              push, pop, full, empty;
  logic [CntW-1:0]   count;
  logic [EntW-1:0]   head;

  assign pop = inst_valid && inst_ready && !redirect;

  pf_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({fetch_pc_q, mem_rdata}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    case (state_q)
      StIdle: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end else if (!full) begin
          state_d = StReq;
          addr_d  = fetch_pc_q;
        end
      end
      StReq: begin
        if (mem_ack && redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = StIdle;
        end else if (mem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + PcOne;
          // Occupancy after this push and any same-cycle pop must stay below DEPTH.
          if ((count - CntW'(pop)) < CntW'(DEPTH - 1)) begin
            addr_d = fetch_pc_q + PcOne;
          end else begin
            state_d = StIdle;
          end
        end else if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = StDrain;
        end
      end
      StDrain: begin
        if (redirect) fetch_pc_d = redirect_pc;
        if (mem_ack)  state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  assign mem_req    = (state_q != StIdle);
  assign mem_addr   = addr_q;
  assign inst_valid = !empty;
  assign inst       = empty ? NOP : head[15:0];
  assign inst_pc    = empty ? '0 : head[EntW-1:16];

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch: fill, drain, redirects, address wrap and async reset.
module tb_inst_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;

  int n_cmp = 0;
  int n_err = 0;
  bit ack_auto = 1'b0;

  always #5 clk = ~clk;

  inst_prefetch #(
    .ADDR_W   (16),
    .DEPTH    (4),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory acks the cycle after a request is seen, returning A000 + address.
  task automatic drive_mem();
    if (ack_auto) begin
      mem_ack   = mem_req;
      mem_rdata = 16'hA000 + mem_addr;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    drive_mem();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_pc", inst_pc, 16'h0000);
    #2 rst = 1'b1;
    ack_auto = 1'b1;

    // Fill with inst_ready=0
    cyc();
    chk("fill_req0", mem_req, 1);
    chk("fill_addr0", mem_addr, 16'h0000);
    cyc();
    chk("fill_addr1", mem_addr, 16'h0001);
    chk("fill_valid", inst_valid, 1);
    chk("fill_inst0", inst, 16'hA000);
    cyc();
    chk("fill_addr2", mem_addr, 16'h0002);
    cyc();
    chk("fill_addr3", mem_addr, 16'h0003);
    cyc();
    chk("full_req", mem_req, 0);
    chk("full_inst", inst, 16'hA000);
    chk("full_pc", inst_pc, 16'h0000);
    chk("full_valid", inst_valid, 1);

    // Drain with inst_ready=1
    inst_ready = 1'b1;
    cyc();
    chk("drain_inst1", inst, 16'hA001);
    chk("drain_req_full", mem_req, 0);
    cyc();
    chk("drain_inst2", inst, 16'hA002);
    chk("drain_req_resume", mem_req, 1);
    chk("drain_addr4", mem_addr, 16'h0004);
    cyc();
    chk("drain_inst3", inst, 16'hA003);
    chk("drain_pc3", inst_pc, 16'h0003);
    chk("drain_addr5", mem_addr, 16'h0005);

    // Redirect with delayed ack
    ack_auto    = 1'b0;
    mem_ack     = 1'b0;
    inst_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    cyc();
    redirect = 1'b0;
    chk("rd1_valid", inst_valid, 0);
    chk("rd1_inst", inst, 16'h0000);
    chk("rd1_req_held", mem_req, 1);
    chk("rd1_addr_held", mem_addr, 16'h0005);
    cyc();
    cyc();
    mem_ack   = 1'b1;
    mem_rdata = 16'hA005;
    cyc();
    mem_ack = 1'b0;
    chk("rd1_drain_req", mem_req, 0);
    chk("rd1_discard", inst_valid, 0);
    cyc();
    chk("rd1_new_req", mem_req, 1);
    chk("rd1_new_addr", mem_addr, 16'h0040);
    ack_auto = 1'b1;
    drive_mem();
    cyc();
    chk("rd1_first_valid", inst_valid, 1);
    chk("rd1_first_pc", inst_pc, 16'h0040);
    chk("rd1_first_inst", inst, 16'hA040);

    // Redirect coinciding with ack and pop
    ack_auto    = 1'b0;
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    cyc();
    redirect   = 1'b0;
    mem_ack    = 1'b0;
    inst_ready = 1'b0;
    chk("rd2_valid", inst_valid, 0);
    chk("rd2_inst", inst, 16'h0000);
    chk("rd2_req", mem_req, 0);
    cyc();
    chk("rd2_req_new", mem_req, 1);
    chk("rd2_addr_new", mem_addr, 16'h0100);
    chk("rd2_no_stale", inst_valid, 0);

    // Redirect to FFFF and wrap
    mem_ack     = 1'b1;
    mem_rdata   = 16'hA100;
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    cyc();
    mem_ack  = 1'b0;
    redirect = 1'b0;
    chk("wrap_idle_valid", inst_valid, 0);
    cyc();
    chk("wrap_addr_ffff", mem_addr, 16'hFFFF);
    ack_auto = 1'b1;
    drive_mem();
    cyc();
    chk("wrap_pc_ffff", inst_pc, 16'hFFFF);
    chk("wrap_inst_ffff", inst, 16'h9FFF);
    chk("wrap_addr_0000", mem_addr, 16'h0000);
    inst_ready = 1'b1;
    cyc();
    chk("wrap_pc_0000", inst_pc, 16'h0000);
    chk("wrap_inst_0000", inst, 16'hA000);
    chk("wrap_req", mem_req, 1);

    // Async reset mid-request
    ack_auto = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_addr", mem_addr, 16'h0000);
    chk("arst_valid", inst_valid, 0);
    chk("arst_inst", inst, 16'h0000);
    chk("arst_pc", inst_pc, 16'h0000);
    inst_ready = 1'b0;
    mem_ack    = 1'b1;
    mem_rdata  = 16'hBEEF;
    cyc();
    chk("arst_ack_ignored", inst_valid, 0);
    mem_ack = 1'b0;
    #2 rst = 1'b1;
    cyc();
    chk("post_req", mem_req, 1);
    chk("post_addr", mem_addr, 16'h0000);
    mem_ack   = 1'b1;
    mem_rdata = 16'h1234;
    cyc();
    mem_ack = 1'b0;
    chk("post_inst", inst, 16'h1234);
    chk("post_pc", inst_pc, 16'h0000);
    chk("post_valid", inst_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
